rsa_decrypt_in: RTL and testbench

Input stage of the decryption path: receives ciphertext bytes from the UART receiver, reads a 32-bit word-count header, assembles little-endian 32-bit ciphertext words, buffers them in a small FIFO and launches them one at a time into the fast modular exponentiator (FME). It emits `last_word_tick` as the final word enters the FME, so the downstream output stage knows which result is last.

---
 rtl/rsa_pkg.sv | 14 +
 rtl/rsa_decrypt_in_if.sv | 28 ++
 rtl/word_fifo.sv | 47 ++++
 rtl/rsa_decrypt_in.sv | 122 ++++++++++++
 tb/tb_rsa_decrypt_in.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decryption datapath.
package rsa_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload,
    StDrain
  } state_e;

endpackage

// File: rtl/rsa_decrypt_in_if.sv
// Control, UART-byte and FME-launch signals of the decryption input stage.
interface rsa_decrypt_in_if;
  import rsa_pkg::*;

  logic              start;
  logic [WORD_W-1:0] n_key;
  logic              rx_done_tick;
  logic [BYTE_W-1:0] rx_data;
  logic              fme_ready;
  logic              word_valid;
  logic [WORD_W-1:0] word_out;
  logic              last_word_tick;
  logic              busy;
  logic              done_tick;
  logic              err_overflow;
  logic              err_range;

  modport master (
    output start, n_key, rx_done_tick, rx_data, fme_ready,
    input  word_valid, word_out, last_word_tick, busy, done_tick, err_overflow, err_range
  );

  modport slave (
    input  start, n_key, rx_done_tick, rx_data, fme_ready,
    output word_valid, word_out, last_word_tick, busy, done_tick, err_overflow, err_range
  );

endinterface

// File: rtl/word_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module word_fifo
  import rsa_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic              do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rsa_decrypt_in.sv
// Decryption input stage: word-count header, LSB-first word assembly, FIFO buffering, FME launch.
module rsa_decrypt_in
  import rsa_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  rsa_decrypt_in_if.slave  bus
);

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [WORD_W-1:0] shift_q, n_words_q, n_key_q, rx_cnt_q, tx_cnt_q;
  logic              launch_q, done_q, err_ovf_q, err_rng_q;

  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head, assembled;
  logic              active, launch, last, byte_in, word_done, push;

  assign active    = (state_q == StPayload) || (state_q == StDrain);
  // launch_q enforces the idle cycle that lets the FME drop fme_ready
  assign launch    = active && !fifo_empty && bus.fme_ready && !launch_q;
  assign last      = launch && (tx_cnt_q + 32'd1 == n_words_q);
  assign byte_in   = bus.rx_done_tick && ((state_q == StHeader) || (state_q == StPayload));
  assign word_done = byte_in && (byte_cnt_q == 2'd3);
  assign assembled = {bus.rx_data, shift_q[WORD_W-1:BYTE_W]};
  assign push      = word_done && (state_q == StPayload);

  word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state_q == StIdle) && bus.start),
    .push  (push),
    .pop   (launch),
    .wdata (assembled),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      n_words_q  <= '0;
      n_key_q    <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      launch_q   <= 1'b0;
      done_q     <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_rng_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      launch_q <= launch;
      if (byte_in) begin
        shift_q    <= assembled;
        byte_cnt_q <= byte_cnt_q + 2'd1;
      end
      if (launch) begin
        tx_cnt_q <= tx_cnt_q + 32'd1;
        if (fifo_head >= n_key_q) err_rng_q <= 1'b1;
      end
      // Dropped words still count as received
      if (push && fifo_full && !launch) err_ovf_q <= 1'b1;
      if (push) rx_cnt_q <= rx_cnt_q + 32'd1;

      case (state_q)
        StIdle: begin
          if (bus.start) begin
            n_key_q    <= bus.n_key;
            byte_cnt_q <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            err_ovf_q  <= 1'b0;
            err_rng_q  <= 1'b0;
            state_q    <= StHeader;
          end
        end
        StHeader: begin
          if (word_done) begin
            n_words_q <= assembled;
            if (assembled == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              state_q <= StPayload;
            end
          end
        end
        StPayload: begin
          if (last) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else if (push && (rx_cnt_q + 32'd1 == n_words_q)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (last) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.word_valid     = launch;
  assign bus.word_out       = launch ? fifo_head : '0;
  assign bus.last_word_tick = last;
  assign bus.busy           = (state_q != StIdle);
  assign bus.done_tick      = done_q;
  assign bus.err_overflow   = err_ovf_q;
  assign bus.err_range      = err_rng_q;

endmodule

// File: tb/tb_rsa_decrypt_in.sv
// Directed bench for rsa_decrypt_in: header parsing, word assembly, launch pacing, errors, reset.
module tb_rsa_decrypt_in;
  import rsa_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rsa_decrypt_in_if bus ();

  rsa_decrypt_in #(
    .DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Launch/tick log, sampled mid-cycle
  logic [31:0] lw_q [$];
  int          lc_q [$];
  int          last_q [$];
  int          done_q [$];
  logic        db_q [$];

  always @(negedge clk) begin
    if (bus.word_valid === 1'b1) begin
      lw_q.push_back(bus.word_out);
      lc_q.push_back(cyc);
    end
    if (bus.last_word_tick === 1'b1) last_q.push_back(cyc);
    if (bus.done_tick === 1'b1) begin
      done_q.push_back(cyc);
      db_q.push_back(bus.busy);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int byte_cyc = 0;
  int w0_cyc   = 0;
  int bw, bl, bd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    bw = lw_q.size();
    bl = last_q.size();
    bd = done_q.size();
  endtask

  task automatic arm(input logic [31:0] k);
    bus.n_key = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    byte_cyc         = cyc;
    tick();
    bus.rx_done_tick = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && bus.busy; i++) tick();
    check_eq(tag, 32'(bus.busy), 32'd0);
    tick();
  endtask

  function automatic logic [31:0] outs();
    return {26'd0, bus.word_valid, bus.last_word_tick, bus.busy, bus.done_tick,
            bus.err_overflow, bus.err_range};
  endfunction

  initial begin
    bus.start        = 1'b0;
    bus.n_key        = '0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = '0;
    bus.fme_ready    = 1'b0;
    repeat (3) tick();
    check_eq("reset_outs", outs(), 32'd0);
    check_eq("reset_word_out", bus.word_out, 32'd0);
    rst = 1'b1;
    tick();

    // Two-word session, FME always ready
    bus.fme_ready = 1'b1;
    mark();
    arm(32'hFFFF_FFFF);
    send_word(32'd2);
    send_word(32'h4433_2211);
    w0_cyc = byte_cyc;
    send_word(32'h8877_6655);
    wait_idle("s1_idle", 50);
    check_eq("s1_count", 32'(lw_q.size() - bw), 32'd2);
    check_eq("s1_word0", lw_q[bw], 32'h4433_2211);
    check_eq("s1_word1", lw_q[bw+1], 32'h8877_6655);
    check_eq("s1_latency", 32'(lc_q[bw]), 32'(w0_cyc + 1));
    check_eq("s1_gap_ok", 32'(lc_q[bw+1] - lc_q[bw] >= 2), 32'd1);
    check_eq("s1_last_cnt", 32'(last_q.size() - bl), 32'd1);
    check_eq("s1_last_cyc", 32'(last_q[bl]), 32'(lc_q[bw+1]));
    check_eq("s1_done_cnt", 32'(done_q.size() - bd), 32'd1);
    check_eq("s1_done_cyc", 32'(done_q[bd]), 32'(last_q[bl] + 1));
    check_eq("s1_done_busy", 32'(db_q[bd]), 32'd0);
    check_eq("s1_errs", {30'd0, bus.err_overflow, bus.err_range}, 32'd0);

    // Zero-length header
    mark();
    arm(32'hFFFF_FFFF);
    send_word(32'd0);
    repeat (3) tick();
    check_eq("s2_done_cnt", 32'(done_q.size() - bd), 32'd1);
    check_eq("s2_done_cyc", 32'(done_q[bd]), 32'(byte_cyc + 1));
    check_eq("s2_no_launch", 32'(lw_q.size() - bw), 32'd0);
    check_eq("s2_no_last", 32'(last_q.size() - bl), 32'd0);
    check_eq("s2_busy", 32'(bus.busy), 32'd0);

    // Overflow: six words into a four-deep FIFO with the FME stalled
    bus.fme_ready = 1'b0;
    mark();
    arm(32'hFFFF_FFFF);
    send_word(32'd6);
    for (int i = 0; i < 6; i++) send_word(32'hA000_0000 + 32'(i));
    check_eq("s3_ovf", 32'(bus.err_overflow), 32'd1);
    check_eq("s3_no_launch", 32'(lw_q.size() - bw), 32'd0);
    bus.fme_ready = 1'b1;
    repeat (20) tick();
    check_eq("s3_count", 32'(lw_q.size() - bw), 32'd4);
    check_eq("s3_word0", lw_q[bw], 32'hA000_0000);
    check_eq("s3_word3", lw_q[bw+3], 32'hA000_0003);
    check_eq("s3_gap", 32'(lc_q[bw+1] - lc_q[bw]), 32'd2);
    check_eq("s3_gap3", 32'(lc_q[bw+3] - lc_q[bw+2]), 32'd2);
    check_eq("s3_busy", 32'(bus.busy), 32'd1);
    check_eq("s3_no_done", 32'(done_q.size() - bd), 32'd0);
    check_eq("s3_no_last", 32'(last_q.size() - bl), 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Range check: equal to modulus flags, one below does not
    mark();
    arm(32'h0000_1000);
    send_word(32'd1);
    send_word(32'h0000_1000);
    wait_idle("s4_idle", 50);
    check_eq("s4_word", lw_q[bw], 32'h0000_1000);
    check_eq("s4_range", 32'(bus.err_range), 32'd1);
    repeat (3) tick();
    check_eq("s4_sticky", 32'(bus.err_range), 32'd1);
    mark();
    arm(32'h0000_1000);
    check_eq("s4_cleared", 32'(bus.err_range), 32'd0);
    send_word(32'd1);
    send_word(32'h0000_0FFF);
    wait_idle("s4b_idle", 50);
    check_eq("s4b_word", lw_q[bw], 32'h0000_0FFF);
    check_eq("s4b_range", 32'(bus.err_range), 32'd0);

    // Reset mid-payload, then a clean session
    mark();
    arm(32'hFFFF_FFFF);
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b0;
    #1;
    check_eq("s5_reset_outs", outs(), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("s5_no_ticks", 32'(done_q.size() - bd + last_q.size() - bl), 32'd0);
    mark();
    arm(32'hFFFF_FFFF);
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    wait_idle("s5_idle", 50);
    check_eq("s5_count", 32'(lw_q.size() - bw), 32'd1);
    check_eq("s5_word", lw_q[bw], 32'hCAFE_F00D);

    // Stray start while busy and extra trailing bytes are ignored
    mark();
    arm(32'hFFFF_FFFF);
    send_word(32'd2);
    send_word(32'h0102_0304);
    arm(32'd0);
    send_word(32'h0506_0708);
    send_word(32'hDEAD_BEEF);
    wait_idle("s6_idle", 50);
    repeat (5) tick();
    check_eq("s6_count", 32'(lw_q.size() - bw), 32'd2);
    check_eq("s6_word1", lw_q[bw+1], 32'h0506_0708);
    check_eq("s6_range", 32'(bus.err_range), 32'd0);
    check_eq("s6_done_cnt", 32'(done_q.size() - bd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
